// File: rtl/lockstep_checker.sv
// Lockstep comparator: two skew-absorbing trace FIFOs, pairwise masked compare, sticky fault flags.
// Optional halt-on-fault behaviour is enabled with `define LOCKSTEP_CHECKER_HALT_EN.
module lockstep_checker #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 16,
    parameter int MAX_SKEW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic [WIDTH-1:0] mask,
    output logic             match_pulse,
    output logic             mismatch_pulse,
    output logic             mismatch_flag,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [CNT_W-1:0] compare_count,
    output logic [WIDTH-1:0] first_a,
    output logic [WIDTH-1:0] first_b,
    output logic [CNT_W-1:0] first_index,
    output logic             overflow_flag,
    output logic             skew_flag,
    output logic             halted
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] SKEW_MAX = CNT_W'(MAX_SKEW);

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [AW:0]      wp_a, rp_a, wp_b, rp_b;
    logic [CNT_W-1:0] skew_cnt;

    logic             run;
    logic             empty_a, empty_b, full_a, full_b;
    logic             pop, push_a, push_b, diff, first_mm;
    logic             one_side, skew_set;
    logic [WIDTH-1:0] head_a, head_b;

`ifdef LOCKSTEP_CHECKER_HALT_EN
    assign run = enable & ~halted;
`else
    assign run    = enable;
    assign halted = 1'b0;
`endif

    assign empty_a = (wp_a == rp_a);
    assign empty_b = (wp_b == rp_b);
    assign full_a  = (wp_a[AW] != rp_a[AW]) && (wp_a[AW-1:0] == rp_a[AW-1:0]);
    assign full_b  = (wp_b[AW] != rp_b[AW]) && (wp_b[AW-1:0] == rp_b[AW-1:0]);
    assign head_a  = mem_a[rp_a[AW-1:0]];
    assign head_b  = mem_b[rp_b[AW-1:0]];

    // A full FIFO still accepts a push when its head leaves on the same edge.
    assign pop      = run & ~empty_a & ~empty_b;
    assign push_a   = run & a_valid & (~full_a | pop);
    assign push_b   = run & b_valid & (~full_b | pop);
    assign diff     = |((head_a ^ head_b) & mask);
    assign first_mm = pop & diff & ~mismatch_flag;
    assign one_side = empty_a ^ empty_b;
    assign skew_set = run & one_side & (skew_cnt < SKEW_MAX) & (skew_cnt + 1'b1 == SKEW_MAX);

    always_ff @(posedge clk) begin
        if (push_a && !clear) mem_a[wp_a[AW-1:0]] <= a_data;
        if (push_b && !clear) mem_b[wp_b[AW-1:0]] <= b_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_a           <= '0;
            rp_a           <= '0;
            wp_b           <= '0;
            rp_b           <= '0;
            skew_cnt       <= '0;
            match_pulse    <= 1'b0;
            mismatch_pulse <= 1'b0;
            mismatch_flag  <= 1'b0;
            mismatch_count <= '0;
            compare_count  <= '0;
            first_a        <= '0;
            first_b        <= '0;
            first_index    <= '0;
            overflow_flag  <= 1'b0;
            skew_flag      <= 1'b0;
`ifdef LOCKSTEP_CHECKER_HALT_EN
            halted         <= 1'b0;
`endif
        end else if (clear) begin
            wp_a           <= '0;
            rp_a           <= '0;
            wp_b           <= '0;
            rp_b           <= '0;
            skew_cnt       <= '0;
            match_pulse    <= 1'b0;
            mismatch_pulse <= 1'b0;
            mismatch_flag  <= 1'b0;
            mismatch_count <= '0;
            compare_count  <= '0;
            first_a        <= '0;
            first_b        <= '0;
            first_index    <= '0;
            overflow_flag  <= 1'b0;
            skew_flag      <= 1'b0;
`ifdef LOCKSTEP_CHECKER_HALT_EN
            halted         <= 1'b0;
`endif
        end else begin
            match_pulse    <= pop & ~diff;
            mismatch_pulse <= pop & diff;
            if (push_a) wp_a <= wp_a + 1'b1;
            if (push_b) wp_b <= wp_b + 1'b1;
            if (pop) begin
                rp_a <= rp_a + 1'b1;
                rp_b <= rp_b + 1'b1;
                if (compare_count != '1) compare_count <= compare_count + 1'b1;
                if (diff) begin
                    mismatch_flag <= 1'b1;
                    if (mismatch_count != '1) mismatch_count <= mismatch_count + 1'b1;
                end
            end
            if (first_mm) begin
                first_a     <= head_a;
                first_b     <= head_b;
                first_index <= compare_count;
            end
            if (run && ((a_valid && !push_a) || (b_valid && !push_b)))
                overflow_flag <= 1'b1;
            // Timer saturates at MAX_SKEW; it only resets once the streams realign or drain.
            if (run) begin
                if (!one_side)
                    skew_cnt <= '0;
                else if (skew_cnt < SKEW_MAX)
                    skew_cnt <= skew_cnt + 1'b1;
            end
            if (skew_set) skew_flag <= 1'b1;
`ifdef LOCKSTEP_CHECKER_HALT_EN
            if (first_mm || skew_set) halted <= 1'b1;
`endif
        end
    end
endmodule

// File: doc/lockstep_checker.md
Name: lockstep_checker

Overview:
- Synthesizable lockstep comparator for two PicoBlaze-class cores running the same program: a DUT core (stream A) and a golden core (stream B).
- Each core supplies a packed trace word per retired instruction: address, port_id, out_port, strobes, flags.
- Per-stream FIFOs absorb bounded skew between the cores. Traces are popped pairwise and compared under a bit mask.
- Mismatches, overflow and excessive skew are reported as sticky flags. Counters and a first-mismatch capture are kept for on-chip debug or bench readback.

Parameters:
- WIDTH, 32, trace word width in bits (>=1).
- DEPTH, 4, entries per stream FIFO; power of two, >=2.
- CNT_W, 16, width of the counters and of first_index.
- MAX_SKEW, 8, cycles one FIFO may stay non-empty while the other is empty before skew_flag sets; >=1, fits in CNT_W.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  1 = accept pushes, perform compares, run skew timer
- clear  in  1  synchronous; flushes FIFOs, zeroes counters, flags and captures
- a_valid  in  1  stream A trace word present this cycle
- a_data  in  WIDTH  stream A trace word
- b_valid  in  1  stream B trace word present this cycle
- b_data  in  WIDTH  stream B trace word
- mask  in  WIDTH  1 = bit participates in the compare; sampled at pop
- match_pulse  out  1  one-cycle pulse, compared pair equal
- mismatch_pulse  out  1  one-cycle pulse, compared pair differs
- mismatch_flag  out  1  sticky, at least one mismatch seen
- mismatch_count  out  CNT_W  saturating count of mismatches
- compare_count  out  CNT_W  saturating count of compared pairs
- first_a  out  WIDTH  A word of the first mismatch
- first_b  out  WIDTH  B word of the first mismatch
- first_index  out  CNT_W  compare_count value at the first mismatch (0-based)
- overflow_flag  out  1  sticky, a push was dropped on a full FIFO
- skew_flag  out  1  sticky, skew timer reached MAX_SKEW
- halted  out  1  see Optional Feature; tied 0 when the feature is compiled out

Behaviour:
- Reset (rst_n=0, asynchronous): every output goes to 0 immediately; FIFOs empty, skew timer 0. Effect is independent of clk.
- Priority: rst_n > clear > normal operation. A valid that coincides with clear is discarded.
- Push: on a clock edge with enable=1 and x_valid=1, x_data is written into FIFO x.
  - A push to a full FIFO succeeds if that FIFO pops on the same edge.
  - Otherwise the word is dropped, the FIFO is unchanged, and overflow_flag is set.
- Pop/compare: when enable=1 and both FIFOs are non-empty at cycle start, both heads are popped on that edge.
  - The result is registered at the same edge: mismatch = |((headA ^ headB) & mask).
  - Aligned inputs: valid at edge k, pop at edge k+1, pulse visible for the one cycle after edge k+1 (latency 2).
- One pop per cycle; sustained throughput is 1 pair per cycle. A pair pushed into empty FIFOs is never bypassed; it always waits one cycle.
- On each compare:
  - compare_count increments, saturating at all-ones.
  - On mismatch, mismatch_count increments (saturating) and mismatch_flag sets.
  - If mismatch_flag was 0 before this compare, first_a, first_b and first_index are captured from the heads and the pre-increment compare_count. Later mismatches never overwrite the capture.
- Skew timer:
  - Increments on each edge where exactly one FIFO is non-empty and enable=1.
  - Clears to 0 when both FIFOs are empty or both are non-empty.
  - When it reaches MAX_SKEW, skew_flag sets and the timer holds at MAX_SKEW.
- enable=0: pushes ignored, no pops, timer held, all state retained; pulses are 0.
- Sticky flags clear only on reset or clear.
- Reset during an in-flight pair: the pair is lost and no pulse is emitted.

Optional Feature:
- Macro: LOCKSTEP_CHECKER_HALT_EN.
- Defined:
  - halted is a register set on the edge that records the first mismatch or sets skew_flag.
  - While halted=1, behaviour is as with enable=0: no pushes, pops or counter updates, and captured state is frozen.
  - halted clears on clear or reset.
- Undefined: halted is a constant 0 and comparison continues after faults.

Test Plan:
- Aligned streams, 10 equal words 0x00000000..0x00000009, mask=0xFFFFFFFF -> 10 match_pulses, compare_count=10, mismatch_flag=0, first pulse 2 edges after first valid.
- Mismatch at index 3 (A=0x000012AB, B=0x000012AC) and again at index 6 -> mismatch_count=2, first_index=3, first_a=0x000012AB, first_b=0x000012AC, unchanged after index 6.
- Same index-3 pair with mask=0xFFFFFFF0 -> match_pulse only, mismatch_flag=0.
- DEPTH=4, B delayed 3 cycles from A over 20 words -> 20 matches, overflow_flag=0, skew_flag=0. Then A pushes 5 words with B silent -> 5th dropped, overflow_flag=1.
- MAX_SKEW=8, A pushes 1 word, B silent -> skew_flag=1 exactly 8 edges after the word is present; rst_n pulsed low mid-run -> all outputs 0 without a clock edge.
- With LOCKSTEP_CHECKER_HALT_EN defined, mismatch at index 3 of 10 -> halted=1, compare_count frozen at 4; clear -> halted=0, counters 0.
